// File: rtl/reg_rename_file_pkg.sv
// Shared sizing for the rename register file: RoB tag width and architectural register count.
package reg_rename_file_pkg;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int REG_NUM        = 32;
endpackage

// File: rtl/reg_read_port.sv
// One source-operand lookup: x0, idle register, optional commit bypass, RoB get-value, else pending.
// Step 3 (commit bypass) is built only when REG_COMMIT_BYPASS_EN is defined.
module reg_read_port #(
  parameter int ROB_W = 4
) (
  input  logic [4:0]       rs,
  input  logic [31:0]      reg_value,
  input  logic             reg_busy,
  input  logic [ROB_W-1:0] reg_tag,
`ifdef REG_COMMIT_BYPASS_EN
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
`endif
  input  logic             get_ready,
  input  logic [31:0]      get_value,
  output logic [ROB_W-1:0] get_rob_id,
  output logic [31:0]      val,
  output logic             dep,
  output logic [ROB_W-1:0] dep_rob_id
);

  always_comb begin
    val        = '0;
    dep        = 1'b0;
    dep_rob_id = '0;
    get_rob_id = (rs != 5'd0 && reg_busy) ? reg_tag : '0;
    if (rs == 5'd0) begin
      val = '0;
    end else if (!reg_busy) begin
      val = reg_value;
`ifdef REG_COMMIT_BYPASS_EN
    end else if (commit_rd == rs && commit_rob_id == reg_tag) begin
      val = commit_value;
`endif
    end else if (get_ready) begin
      val = get_value;
    end else begin
      dep        = 1'b1;
      dep_rob_id = reg_tag;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags: issue renames rd, commit retires values, two lookups.
// Optional commit-value bypass in the lookups is enabled by defining REG_COMMIT_BYPASS_EN.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_W = ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic [4:0]       issue_rd,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [ROB_W-1:0] get_rob_id1,
  output logic [ROB_W-1:0] get_rob_id2,
  input  logic             get_ready1,
  input  logic             get_ready2,
  input  logic [31:0]      get_value1,
  input  logic [31:0]      get_value2,
  output logic [31:0]      val1,
  output logic [31:0]      val2,
  output logic             dep1,
  output logic             dep2,
  output logic [ROB_W-1:0] dep_rob_id1,
  output logic [ROB_W-1:0] dep_rob_id2
);

  logic [31:0]      value_q [REG_NUM];
  logic [ROB_W-1:0] tag_q   [REG_NUM];
  logic [REG_NUM-1:0] busy_q;

  logic issue_en;
  logic commit_en;
  assign issue_en  = !clear && issue_rd != 5'd0;
  assign commit_en = commit_rd != 5'd0;

  // Entry 0 is reset and never written, so x0 stays 0 and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_en) begin
        value_q[commit_rd] <= commit_value;
        if (tag_q[commit_rd] == commit_rob_id && !(issue_en && issue_rd == commit_rd))
          busy_q[commit_rd] <= 1'b0;
      end
      if (clear) begin
        busy_q <= '0;
        for (int i = 0; i < REG_NUM; i++) tag_q[i] <= '0;
      end else if (issue_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_id;
      end
    end
  end

  reg_read_port #(.ROB_W(ROB_W)) u_port1 (
    .rs            (rs1),
    .reg_value     (value_q[rs1]),
    .reg_busy      (busy_q[rs1]),
    .reg_tag       (tag_q[rs1]),
`ifdef REG_COMMIT_BYPASS_EN
    .commit_rd     (commit_rd),
    .commit_rob_id (commit_rob_id),
    .commit_value  (commit_value),
`endif
    .get_ready     (get_ready1),
    .get_value     (get_value1),
    .get_rob_id    (get_rob_id1),
    .val           (val1),
    .dep           (dep1),
    .dep_rob_id    (dep_rob_id1)
  );

  reg_read_port #(.ROB_W(ROB_W)) u_port2 (
    .rs            (rs2),
    .reg_value     (value_q[rs2]),
    .reg_busy      (busy_q[rs2]),
    .reg_tag       (tag_q[rs2]),
`ifdef REG_COMMIT_BYPASS_EN
    .commit_rd     (commit_rd),
    .commit_rob_id (commit_rob_id),
    .commit_value  (commit_value),
`endif
    .get_ready     (get_ready2),
    .get_value     (get_value2),
    .get_rob_id    (get_rob_id2),
    .val           (val2),
    .dep           (dep2),
    .dep_rob_id    (dep_rob_id2)
  );

endmodule
